// File: rtl/cache_mem.sv
// Direct-mapped word cache: 2^INDEX_W lines of four 32-bit words with a combinational hit path.
// Optional hit counter enabled by defining CACHE_HIT_COUNTER_EN; otherwise counter_out is tied to 0.
module cache_mem #(
    parameter int ADDR_W  = 15,
    parameter int INDEX_W = 10,
    parameter int CNT_W   = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data1,
    input  logic [31:0]       data2,
    input  logic [31:0]       data3,
    input  logic [31:0]       data4,
    output logic              Memread,
    output logic [31:0]       Out,
    output logic [CNT_W-1:0]  counter_out
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    logic [1:0]         offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill;
    logic [31:0]        fill_word   [4];
    logic [31:0]        cached_word [4];
    logic [TAG_W-1:0]   tag_mem     [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   valid_d;

    assign offset = address[1:0];
    assign index  = address[INDEX_W+1:2];
    assign tag    = address[ADDR_W-1:INDEX_W+2];

    assign fill_word[0] = data1;
    assign fill_word[1] = data2;
    assign fill_word[2] = data3;
    assign fill_word[3] = data4;

    // Only valid bits are reset; tag/data contents are meaningless until valid is set.
    assign hit     = valid_q[index] && (tag_mem[index] == tag);
    assign fill    = read && !hit;
    assign Memread = fill;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            logic [31:0] word_mem [LINES];

            always_ff @(posedge clk) begin
                if (fill) begin
                    word_mem[index] <= fill_word[gi];
                end
            end

            assign cached_word[gi] = word_mem[index];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[index] <= tag;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (fill) begin
            valid_d[index] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // On a miss the external memory words are forwarded so the requester sees data the same cycle.
    always_comb begin
        Out = '0;
        if (read) begin
            Out = hit ? cached_word[offset] : fill_word[offset];
        end
    end

`ifdef CACHE_HIT_COUNTER_EN
    logic [CNT_W-1:0]  counter_q;
    logic [CNT_W-1:0]  counter_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] last_addr_d;
    logic              first_seen_q;
    logic              first_seen_d;
    logic              new_access;

    // Only the first cycle of a hit on a fresh address counts; a miss-then-fill is never counted.
    always_comb begin
        new_access   = !first_seen_q || (address != last_addr_q);
        counter_d    = counter_in;
        last_addr_d  = last_addr_q;
        first_seen_d = first_seen_q;
        if (read) begin
            last_addr_d  = address;
            first_seen_d = 1'b1;
            if (new_access && hit) begin
                counter_d = counter_in + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q    <= '0;
            last_addr_q  <= '0;
            first_seen_q <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            last_addr_q  <= last_addr_d;
            first_seen_q <= first_seen_d;
        end
    end

    assign counter_out = counter_q;
`else
    logic unused_counter_in;
    assign unused_counter_in = ^counter_in;
    assign counter_out       = '0;
`endif

endmodule

// File: tb/tb_cache_mem.sv
// Directed bench for cache_mem: memory model word[a]=a, per-cycle model comparison plus literal pins.
module tb_cache_mem;

`ifdef CACHE_HIT_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        read    = 1'b0;
    logic [14:0] address = '0;
    logic [31:0] data1, data2, data3, data4;
    logic        Memread;
    logic [31:0] Out;
    logic [13:0] counter_in, counter_out;
    logic        force_en  = 1'b0;
    logic [13:0] force_val = '0;

    int checks = 0;
    int passes = 0;

    always #60 clk = ~clk;

    assign data1 = {17'd0, address[14:2], 2'b00};
    assign data2 = data1 + 32'd1;
    assign data3 = data1 + 32'd2;
    assign data4 = data1 + 32'd3;
    assign counter_in = force_en ? force_val : counter_out;

    cache_mem #(.ADDR_W(15), .INDEX_W(10), .CNT_W(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .counter_in (counter_in),
        .read       (read),
        .address    (address),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .data4      (data4),
        .Memread    (Memread),
        .Out        (Out),
        .counter_out(counter_out)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Model: a map index -> tag of lines present; memory content equals address, so Out must equal address.
    int model_tag [int];
    int last_addr_m = 0;
    bit seen_m      = 1'b0;
    int exp_cnt     = 0;

    always @(negedge clk) begin
        int idx, tg, cin, nxt;
        bit hit_m, new_m;
        idx = int'(address[11:2]);
        tg  = int'(address[14:12]);
        if (reset) begin
            model_tag.delete();
            seen_m      = 1'b0;
            last_addr_m = 0;
            exp_cnt     = 0;
        end
        hit_m = read && !reset && model_tag.exists(idx) && (model_tag[idx] == tg);
        check("memread", {31'd0, read && !hit_m}, {31'd0, Memread} ^ 32'd0);
        check("out", Out, read ? {17'd0, address} : 32'd0);
        check("counter", {18'd0, counter_out}, exp_cnt);
        if (!reset) begin
            cin   = force_en ? int'(force_val) : exp_cnt;
            nxt   = cin;
            new_m = !seen_m || (int'(address) != last_addr_m);
            if (read) begin
                if (new_m && hit_m) nxt = (cin + 1) % 16384;
                last_addr_m = int'(address);
                seen_m      = 1'b1;
                if (!hit_m) model_tag[idx] = tg;
            end
            exp_cnt = CNT_EN ? nxt : 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic r, input logic [14:0] a);
        read    = r;
        address = a;
        $display("access read=%0d addr=%0d t=%0t", r, a, $time);
    endtask

    logic [14:0] sweep [4];

    initial begin
        // Reset phase with a read already pending: no line valid, so it must request memory.
        start(1'b1, 15'd1024);
        #30;
        check("rst_memread", {31'd0, Memread}, 32'd1);
        check("rst_cnt", {18'd0, counter_out}, 32'd0);
        tick(2);
        reset = 1'b0;

        // First access after reset: miss then hit with no count.
        #30;
        check("c1_memread", {31'd0, Memread}, 32'd1);
        check("c1_out", Out, 32'd1024);
        tick(1);
        #30;
        check("c2_memread", {31'd0, Memread}, 32'd0);
        check("c2_out", Out, 32'd1024);
        check("c2_cnt", {18'd0, counter_out}, 32'd0);
        tick(1);

        // Remaining words of the line: three fresh hits.
        for (int k = 1; k < 4; k++) begin
            start(1'b1, 15'(1024 + k));
            #30;
            check("line_hit", {31'd0, Memread}, 32'd0);
            check("line_out", Out, 32'(1024 + k));
            tick(2);
        end
        check("line_cnt", {18'd0, counter_out}, CNT_EN ? 32'd3 : 32'd0);

        // Conflict on index 256: tag 1 evicts tag 0, then tag 0 misses again.
        start(1'b1, 15'd5120);
        #30;
        check("conf_memread", {31'd0, Memread}, 32'd1);
        check("conf_out", Out, 32'd5120);
        tick(2);
        start(1'b1, 15'd1024);
        #30;
        check("evict_memread", {31'd0, Memread}, 32'd1);
        tick(2);
        check("conf_cnt", {18'd0, counter_out}, CNT_EN ? 32'd3 : 32'd0);

        // Idle reads: no output, no fill, even on a cached address.
        start(1'b0, 15'd2048);
        #30;
        check("idle_memread", {31'd0, Memread}, 32'd0);
        check("idle_out", Out, 32'd0);
        tick(2);
        start(1'b0, 15'd1024);
        #30;
        check("idle_hit_out", Out, 32'd0);
        tick(2);
        start(1'b1, 15'd2048);
        #30;
        check("after_idle_miss", {31'd0, Memread}, 32'd1);
        tick(2);

        // Address-space corners.
        sweep[0] = 15'd0;
        sweep[1] = 15'd32767;
        sweep[2] = 15'd32764;
        sweep[3] = 15'd2;
        foreach (sweep[i]) begin
            start(1'b1, sweep[i]);
            tick(2);
        end

        // Counter wrap: counter_in forced to all ones on a fresh hit.
        force_en  = 1'b1;
        force_val = 14'd16383;
        start(1'b1, 15'd32766);
        #30;
        check("wrap_hit", {31'd0, Memread}, 32'd0);
        tick(1);
        force_en = 1'b0;
        check("wrap_cnt", {18'd0, counter_out}, 32'd0);
        tick(1);

        // Reset asserted mid-miss abandons the fill and flushes earlier lines.
        start(1'b1, 15'd12288);
        #30;
        check("mid_memread", {31'd0, Memread}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_cnt", {18'd0, counter_out}, 32'd0);
        check("mid_rst_memread", {31'd0, Memread}, 32'd1);
        tick(1);
        reset = 1'b0;
        #30;
        check("abandon_miss", {31'd0, Memread}, 32'd1);
        tick(1);
        start(1'b1, 15'd1024);
        #30;
        check("flush_miss", {31'd0, Memread}, 32'd1);
        check("flush_out", Out, 32'd1024);
        tick(2);
        check("final_cnt", {18'd0, counter_out}, 32'd0);

        read = 1'b0;
        tick(1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem.md
CACHE_MEM -- requirements
Module: cache_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width.
REQ-002 SHALL have parameter INDEX_W, default 10, line-index width (1024 lines).
REQ-003 SHALL have parameter CNT_W, default 14, hit-counter width.
REQ-004 SHALL use one clock and asynchronous active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have reset  input  1  asynchronous, active-high; clears all valid bits and registers.
REQ-006 SHALL have counter_in  input  CNT_W  current hit count, fed back externally from counter_out.
REQ-007 SHALL have read  input  1  read request for address.
REQ-008 SHALL have address  input  ADDR_W  word address: offset [1:0], index [11:2], tag [14:12].
REQ-009 SHALL have data1..data4  input  32 each  memory words {address[14:2],2'b00}+0..+3; combinational from the external memory.
REQ-010 SHALL have Memread  output  1  memory block-read request.
REQ-011 SHALL have Out  output  32  word selected by address[1:0].
REQ-012 SHALL have counter_out  output  CNT_W  registered hit count.

Function
REQ-013 SHALL be direct-mapped: 2^INDEX_W lines, each holding valid, 3-bit tag and four 32-bit words.
REQ-014 Hit SHALL be combinational: valid[index] && tag[index]==address[14:12].
REQ-015 Memread SHALL be combinational: read && !hit; 0 when read=0.
REQ-016 On a rising edge with Memread=1, SHALL write data1..data4 into line[index], set the tag and valid=1, evicting any prior contents.
REQ-017 Miss latency SHALL be one cycle: the access hits on the cycle after the fill.
REQ-018 Out SHALL be combinational: the cached word[offset] on hit; data1..data4[offset] passed through on miss; 0 when read=0.
REQ-019 SHALL register last_addr and a first_seen flag; an access is new when first_seen=0 or address!=last_addr. Both SHALL update each edge with read=1.
REQ-020 On an edge with read=1, a new access and hit=1, counter_out SHALL be loaded with counter_in+1, modulo 2^CNT_W (16383 wraps to 0).
REQ-021 On all other edges counter_out SHALL be loaded with counter_in, i.e. hold with feedback. A miss-then-fill access is therefore not counted.
REQ-022 When read=0: no fill occurs, counter_out is unchanged, and last_addr is not updated.
REQ-023 A fill and a same-edge address change SHALL use the address sampled at that edge.

Reset
REQ-024 Reset SHALL take effect asynchronously: all valid bits=0, counter_out=0, first_seen=0, last_addr=0.
REQ-025 During reset, Memread=read, since no line is valid, and no fill SHALL occur.
REQ-026 Tag and data arrays SHALL need no reset.
REQ-027 Reset asserted mid-miss SHALL abandon the fill; the line SHALL stay invalid.

Configuration
REQ-028 Macro CACHE_HIT_COUNTER_EN defined: REQ-019..REQ-021 apply.
REQ-029 Macro CACHE_HIT_COUNTER_EN undefined: counter_out SHALL be constant 0, last_addr and first_seen SHALL be omitted, and counter_in SHALL be ignored. Cache function SHALL be unchanged.

Verification
Bench memory preload: word[a] = a.
Bench period: clk 120 ns; address held 2 cycles per access; counter_out wired back to counter_in.
REQ-030 Reset, then read=1, address=1024: cycle 1 Memread=1, Out=1024; cycle 2 Memread=0, Out=1024; counter_out=0.
REQ-031 Addresses 1024,1025,1026,1027, 2 cycles each: one miss then three new hits; counter_out=3; Out=1025/1026/1027.
REQ-032 Conflict: 1024 filled, then 5120 (same index, tag 1): Memread=1, Out=5120. Then 1024 again: miss again; counter_out unchanged on both.
REQ-033 read=0 with any address: Memread=0, Out=0, counter_out held, no line filled; next read of the same address misses.
REQ-034 Counter wrap: force counter_in=16383, then one new hit -> counter_out=0. Reset mid-run -> counter_out=0 and the previously cached 1024 misses.
